// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_pkg
// Brief    : Shared types and constants for the FP32 dot-product sequencer.
// Revision : 1.0
// ============================================================================
package mac_pkg;

    localparam int          XLEN          = 32;
    localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/mac_dot_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_dot_seq_if
// Brief    : Command, element stream, MAC operand and result signals of the
//            dot-product sequencer.
// Revision : 1.0
// ============================================================================
interface mac_dot_seq_if #(
    parameter int XLEN  = 32,
    parameter int LEN_W = 16
);
    logic             start_i;
    logic [LEN_W-1:0] len_i;
    logic             busy_o;

    logic             elem_valid_i;
    logic             elem_ready_o;
    logic [XLEN-1:0]  elem_b_i;
    logic [XLEN-1:0]  elem_c_i;

    logic [XLEN-1:0]  mac_a_o;
    logic [XLEN-1:0]  mac_b_o;
    logic [XLEN-1:0]  mac_c_o;
    logic [XLEN-1:0]  mac_result_i;

    logic             res_valid_o;
    logic             res_ready_i;
    logic [XLEN-1:0]  res_data_o;

    modport slave (
        input  start_i, len_i, elem_valid_i, elem_b_i, elem_c_i,
               mac_result_i, res_ready_i,
        output busy_o, elem_ready_o, mac_a_o, mac_b_o, mac_c_o,
               res_valid_o, res_data_o
    );

    modport master (
        output start_i, len_i, elem_valid_i, elem_b_i, elem_c_i,
               mac_result_i, res_ready_i,
        input  busy_o, elem_ready_o, mac_a_o, mac_b_o, mac_c_o,
               res_valid_o, res_data_o
    );

endinterface : mac_dot_seq_if
`default_nettype wire

// File: rtl/mac_dot_seq.sv
`default_nettype none
// ============================================================================
// Module   : mac_dot_seq
// Brief    : Streams (b, c) pairs into a one-cycle registered FP32 FMA and
//            returns the accumulated dot product over a valid/ready port.
// Revision : 1.0
// ============================================================================
module mac_dot_seq #(
    parameter int XLEN  = 32,
    parameter int LEN_W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mac_dot_seq_if.slave      bus
);
    import mac_pkg::*;

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] remaining_q;
    logic [XLEN-1:0]  acc_q;
    logic             fwd_q;
    logic             res_valid_q;
    logic [XLEN-1:0]  res_data_q;
    logic             issue;

    assign bus.busy_o       = (state_q != IDLE);
    assign bus.elem_ready_o = (state_q == RUN);
    assign issue            = bus.elem_valid_i & bus.elem_ready_o;

    // The previous sum is still in flight inside the MAC when issues are
    // back-to-back, so it is taken straight from the MAC output.
    assign bus.mac_a_o = issue ? (fwd_q ? bus.mac_result_i : acc_q) : '0;
    assign bus.mac_b_o = issue ? bus.elem_b_i : '0;
    assign bus.mac_c_o = issue ? bus.elem_c_i : '0;

    assign bus.res_valid_o = res_valid_q;
    assign bus.res_data_o  = res_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = (bus.len_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue && (remaining_q == LEN_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (bus.res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining_q <= '0;
            acc_q       <= '0;
            fwd_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            fwd_q <= issue;
            if (fwd_q) begin
                acc_q <= bus.mac_result_i;
            end
            if (issue) begin
                remaining_q <= remaining_q - LEN_W'(1);
            end

            unique case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        remaining_q <= bus.len_i;
                        acc_q       <= XLEN'(FP32_POS_ZERO);
                        fwd_q       <= 1'b0;
                        if (bus.len_i == '0) begin
                            res_data_q  <= XLEN'(FP32_POS_ZERO);
                            res_valid_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    res_data_q  <= bus.mac_result_i;
                    res_valid_q <= 1'b1;
                end
                DONE: begin
                    if (bus.res_ready_i) begin
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : mac_dot_seq
`default_nettype wire

// File: tb/tb_mac_dot_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_dot_seq
// Brief    : Directed self-checking bench for mac_dot_seq with a behavioural
//            one-cycle FMA standing in for the MAC.
// Revision : 1.0
// ============================================================================
module tb_mac_dot_seq;

    typedef struct {
        logic [15:0]      len;
        logic [2:0][31:0] b;
        logic [2:0][31:0] c;
        logic [2:0][31:0] a;     // expected A operand for each element
        int               gap;   // bubble cycles between elements
        logic [31:0]      res;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mac_dot_seq_if #(.XLEN(32), .LEN_W(16)) bus ();

    mac_dot_seq #(.XLEN(32), .LEN_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact-value FP32 helpers: normal numbers and zero only.
    function automatic real f2r(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:0] == 31'd0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.mac_result_i <= 32'd0;
        else        bus.mac_result_i <= r2f(f2r(bus.mac_a_o) + f2r(bus.mac_b_o) * f2r(bus.mac_c_o));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  edges;
        int  k;
        int  gapcnt;
        bit  got;
        bit  acc;
        edges  = 0;
        k      = 0;
        gapcnt = 0;
        got    = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.len_i   = v.len;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        while (!got && edges < 100) begin
            @(negedge clk);
            if (k < int'(v.len) && gapcnt == 0) begin
                bus.elem_valid_i = 1'b1;
                bus.elem_b_i     = v.b[k];
                bus.elem_c_i     = v.c[k];
            end else begin
                bus.elem_valid_i = 1'b0;
            end
            #1;
            if (bus.elem_valid_i) begin
                chk({tag, " ready"}, {31'd0, bus.elem_ready_o}, 32'd1);
                chk({tag, " mac_a"}, bus.mac_a_o, v.a[k]);
                chk({tag, " mac_b"}, bus.mac_b_o, v.b[k]);
                chk({tag, " mac_c"}, bus.mac_c_o, v.c[k]);
                if (k > 0 && v.gap == 0)
                    chk({tag, " fwd"}, bus.mac_a_o, bus.mac_result_i);
            end
            if (v.len == 16'd0)
                chk({tag, " ready_low"}, {31'd0, bus.elem_ready_o}, 32'd0);
            acc = bus.elem_valid_i & bus.elem_ready_o;
            @(posedge clk);
            edges++;
            if (acc) begin
                k++;
                gapcnt = v.gap;
            end else if (gapcnt > 0) begin
                gapcnt--;
            end
            #1 bus.elem_valid_i = 1'b0;
            if (bus.res_valid_o) got = 1'b1;
        end
        chk({tag, " done"}, {31'd0, got}, 32'd1);
        chk({tag, " latency"}, edges,
            int'(v.len) + 1 + ((v.len > 16'd0) ? v.gap * (int'(v.len) - 1) : 0));
        chk({tag, " result"}, bus.res_data_o, v.res);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        bus.res_ready_i = 1'b1;
        @(posedge clk);
        #1 bus.res_ready_i = 1'b0;
        chk({tag, " valid_clr"}, {31'd0, bus.res_valid_o}, 32'd0);
        chk({tag, " idle"}, {31'd0, bus.busy_o}, 32'd0);
    endtask

    vec_t tbl [4];
    vec_t rv;

    initial begin
        checks = 0;
        errors = 0;
        rst_n            = 1'b0;
        bus.start_i      = 1'b0;
        bus.len_i        = '0;
        bus.elem_valid_i = 1'b0;
        bus.elem_b_i     = '0;
        bus.elem_c_i     = '0;
        bus.res_ready_i  = 1'b0;

        tbl[0] = '{len: 16'd3,
                   b: {32'h40400000, 32'h40000000, 32'h3F800000},
                   c: {32'h40800000, 32'h40800000, 32'h40800000},
                   a: {32'h41400000, 32'h40800000, 32'h00000000},
                   gap: 0, res: 32'h41C00000};
        tbl[1] = tbl[0];
        tbl[1].gap = 2;
        tbl[2] = '{len: 16'd2,
                   b: {32'h0, 32'h40000000, 32'h40000000},
                   c: {32'h0, 32'hC0400000, 32'h40400000},
                   a: {32'h0, 32'h40C00000, 32'h00000000},
                   gap: 0, res: 32'h00000000};
        tbl[3] = '{len: 16'd0, b: '0, c: '0, a: '0, gap: 0, res: 32'h00000000};
        rv     = '{len: 16'd1,
                   b: {32'h0, 32'h0, 32'h3F000000},
                   c: {32'h0, 32'h0, 32'hC0800000},
                   a: '0, gap: 0, res: 32'hC0000000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy",  {31'd0, bus.busy_o},       32'd0);
        chk("rst ready", {31'd0, bus.elem_ready_o}, 32'd0);
        chk("rst valid", {31'd0, bus.res_valid_o},  32'd0);
        chk("rst data",  bus.res_data_o, 32'd0);
        chk("rst mac_a", bus.mac_a_o, 32'd0);
        chk("rst mac_b", bus.mac_b_o, 32'd0);
        chk("rst mac_c", bus.mac_c_o, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
            handshake($sformatf("vec%0d hs", i));
        end

        // Result backpressure with start pulses that must be ignored.
        run_vec(tbl[0], "bp");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.start_i = 1'b1;
            bus.len_i   = 16'd1;
            #1;
            chk("bp valid", {31'd0, bus.res_valid_o}, 32'd1);
            chk("bp data",  bus.res_data_o, 32'h41C00000);
            chk("bp busy",  {31'd0, bus.busy_o}, 32'd1);
            @(posedge clk);
            #1 bus.start_i = 1'b0;
        end
        handshake("bp hs");
        @(negedge clk);
        chk("bp stay idle", {31'd0, bus.busy_o}, 32'd0);

        // Reset after the first of three elements.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.len_i   = 16'd3;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        @(negedge clk);
        bus.elem_valid_i = 1'b1;
        bus.elem_b_i     = 32'h3F800000;
        bus.elem_c_i     = 32'h40800000;
        @(posedge clk);
        #1 bus.elem_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst busy",  {31'd0, bus.busy_o},       32'd0);
        chk("mrst ready", {31'd0, bus.elem_ready_o}, 32'd0);
        chk("mrst valid", {31'd0, bus.res_valid_o},  32'd0);
        chk("mrst data",  bus.res_data_o, 32'd0);
        chk("mrst mac_a", bus.mac_a_o, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(rv, "after_rst");
        handshake("after_rst hs");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mac_dot_seq
`default_nettype wire

// File: doc/mac_dot_seq.md
Name: mac_dot_seq

Overview:
- Upstream sequencer for the registered FP32 fused multiply-add (MAC32_top: Result = A + B*C, one-cycle latency).
- Accepts a vector length and a stream of (b, c) element pairs, then drives the MAC operands, feeding the previous sum back as A.
- Returns the completed single-precision dot product over a valid/ready result port.
- Sustains one element per cycle by forwarding the MAC result directly into A.

Parameters:
XLEN, 32, floating-point word width; must match the MAC.
LEN_W, 16, width of the vector-length field.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start_i  in  1  begin a dot product; sampled only in IDLE
len_i  in  LEN_W  element count, latched on start
busy_o  out  1  high in any state other than IDLE
elem_valid_i  in  1  element pair valid
elem_ready_o  out  1  element pair accepted when valid & ready
elem_b_i  in  XLEN  multiplicand
elem_c_i  in  XLEN  multiplier
mac_a_o  out  XLEN  MAC A operand (accumulator)
mac_b_o  out  XLEN  MAC B operand
mac_c_o  out  XLEN  MAC C operand
mac_result_i  in  XLEN  registered MAC result
res_valid_o  out  1  dot-product result valid
res_ready_i  in  1  result consumer ready
res_data_o  out  XLEN  dot-product result

Behaviour:
- Reset values:
  - State is IDLE.
  - busy_o, elem_ready_o and res_valid_o are 0.
  - res_data_o, acc_q, remaining_q and fwd_q are 0.
  - With no issue, mac_a_o, mac_b_o and mac_c_o are 0, per the operand rule below.
- Reset mid-operation abandons the dot product. There is no partial output.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start_i=1 latches len_i into remaining_q and sets acc_q = +0 (0x00000000) and fwd_q = 0.
  - len_i==0: next state DONE with res_data_o = 0x00000000.
  - Otherwise: next state RUN.
- RUN:
  - elem_ready_o = 1, combinational from state.
  - issue = elem_valid_i & elem_ready_o.
- Operand drive:
  - On issue: mac_b_o = elem_b_i, mac_c_o = elem_c_i, mac_a_o = fwd_q ? mac_result_i : acc_q.
  - Without issue: all three operands are driven 0.
- Sequential updates:
  - fwd_q <= issue.
  - If fwd_q: acc_q <= mac_result_i, capturing the sum of the previous issue.
  - On issue: remaining_q decrements.
  - Issue with remaining_q==1: next state DRAIN.
- Bubbles:
  - elem_valid_i low for any number of cycles is legal.
  - The accumulator is held in acc_q.
  - The MAC output from zero operands is ignored because fwd_q=0.
- DRAIN (exactly one cycle):
  - res_data_o <= mac_result_i, the final sum.
  - res_valid_o <= 1.
  - Next state DONE.
- DONE:
  - res_valid_o and res_data_o are held stable until res_ready_i is high.
  - On handshake: res_valid_o <= 0, next state IDLE.
- start_i is ignored outside IDLE. Elements offered outside RUN are not accepted.
- Latency: res_valid_o rises at the edge after the edge that accepts the last element.
  - With back-to-back elements, that is len+1 edges after the start edge.
- IEEE rounding, special cases and NaN/Inf propagation are owned by the MAC. The sequencer never inspects operand values.
- remaining_q never wraps: the transition to DRAIN happens at 1. The len=0 case bypasses RUN.

Decomposition:
- Shared package (mac_pkg) holds:
  - The state enum {IDLE, RUN, DRAIN, DONE}.
  - Constants FP32_POS_ZERO = 32'h0000_0000 and XLEN = 32.
- No sub-module. The counter, forward mux and FSM sit in one module.
- The integration test instantiates mac_dot_seq together with MAC32_top.

Test Plan:
- Back-to-back stream:
  - Stimulus: len=3, b={1.0,2.0,3.0} = {3F800000,40000000,40400000}, c all 4.0 = 40800000, elem_valid held high.
  - Response: res_data_o = 41C00000 (24.0); res_valid_o 4 edges after the start edge; mac_a_o forwarded from mac_result_i on elements 2 and 3.
- Bubbled stream:
  - Stimulus: same vectors with elem_valid_i low for 2 cycles between elements.
  - Response: 41C00000; mac_a_o equals acc_q, not mac_result_i, after each bubble.
- Zero length:
  - Stimulus: len=0.
  - Response: elem_ready_o never high; res_valid_o at the next edge with res_data_o = 00000000.
- Result backpressure:
  - Stimulus: res_ready_i low for 3 cycles in DONE, with start_i pulsed.
  - Response: res_valid_o and res_data_o stable; busy_o = 1; start ignored; IDLE after the handshake.
- Reset mid-RUN:
  - Stimulus: assert rst_n low after 1 of 3 elements, then run a new len=1 with b=3F000000 (0.5), c=C0800000 (-4.0).
  - Response: all outputs 0 during reset; new result C0000000 (-2.0), with no stale accumulator.
- Mixed signs:
  - Stimulus: len=2, b={2.0,2.0}, c={3.0,-3.0}.
  - Response: res_data_o = 00000000 (+0).
